// File: rtl/qnigma_chacha20_pkg.sv
// Shared constants and loader state encoding for the qnigma ChaCha20 datapath.
package qnigma_chacha20_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned KEY_BYTES  = 32;
    localparam int unsigned NON_BYTES  = 12;
    localparam int unsigned INI_BYTES  = 4;
    localparam int unsigned CNT_WIDTH  = $clog2(KEY_BYTES);
    localparam int unsigned FRM_CNT_WIDTH = 32;
    localparam int unsigned ERR_CNT_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_NON,
        ST_CNT,
        ST_PAY,
        ST_DONE
    } loader_state_e;

endpackage

// File: rtl/qnigma_chacha20_loader.sv
// Header parser in front of the ChaCha20 core: latches key/nonce/counter and forwards the payload.
// Optional frame/error statistics ports are built when QNIGMA_CHACHA20_LOADER_STAT_EN is defined.
module qnigma_chacha20_loader
    import qnigma_chacha20_pkg::*;
#(
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     dat_i,
    input  logic                      val_i,
    input  logic                      sof_i,
    input  logic                      eof_i,
    output logic                      cts_o,
    output logic [8*KEY_BYTES-1:0]    key,
    output logic [8*NON_BYTES-1:0]    non,
    output logic [8*INI_BYTES-1:0]    ini,
    output logic                      core_rst,
    output logic [DATA_WIDTH-1:0]     dat_o,
    output logic                      val_o,
    output logic                      sof_o,
    output logic                      eof_o,
    input  logic                      cts_i,
    output logic [LEN_WIDTH-1:0]      len,
    output logic                      err,
    output logic                      don
`ifdef QNIGMA_CHACHA20_LOADER_STAT_EN
    ,
    output logic [FRM_CNT_WIDTH-1:0]  frm_cnt,
    output logic [ERR_CNT_WIDTH-1:0]  err_cnt
`endif
);

    loader_state_e                state, state_d;
    logic [CNT_WIDTH-1:0]         cnt, cnt_d;
    logic                         first, first_d;
    logic [8*KEY_BYTES-1:0]       key_d;
    logic [8*NON_BYTES-1:0]       non_d;
    logic [8*INI_BYTES-1:0]       ini_d;
    logic [LEN_WIDTH-1:0]         len_d;
    logic                         core_rst_d;
    logic                         err_d;
    logic                         don_d;
    logic [DATA_WIDTH-1:0]        dat_o_d;
    logic                         val_o_d;
    logic                         sof_o_d;
    logic                         eof_o_d;
    logic                         acc;

    // Only the payload phase is throttled by the core; header bytes are always taken.
    assign cts_o = (state == ST_PAY) ? cts_i : 1'b1;
    assign acc   = val_i & cts_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            first    <= 1'b0;
            key      <= '0;
            non      <= '0;
            ini      <= '0;
            len      <= '0;
            core_rst <= 1'b1;
            err      <= 1'b0;
            don      <= 1'b0;
            dat_o    <= '0;
            val_o    <= 1'b0;
            sof_o    <= 1'b0;
            eof_o    <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            first    <= first_d;
            key      <= key_d;
            non      <= non_d;
            ini      <= ini_d;
            len      <= len_d;
            core_rst <= core_rst_d;
            err      <= err_d;
            don      <= don_d;
            dat_o    <= dat_o_d;
            val_o    <= val_o_d;
            sof_o    <= sof_o_d;
            eof_o    <= eof_o_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        first_d    = first;
        key_d      = key;
        non_d      = non;
        ini_d      = ini;
        len_d      = len;
        core_rst_d = core_rst;
        err_d      = 1'b0;
        don_d      = 1'b0;
        dat_o_d    = dat_o;
        val_o_d    = val_o;
        sof_o_d    = sof_o;
        eof_o_d    = eof_o;

        // Output beat is consumed whenever the core is ready; otherwise it is held.
        if (cts_i) begin
            val_o_d = 1'b0;
            sof_o_d = 1'b0;
            eof_o_d = 1'b0;
        end

        unique case (state)
            // DONE behaves like IDLE for input so a frame may start right after the last one.
            ST_IDLE, ST_DONE: begin
                core_rst_d = 1'b1;
                don_d      = (state == ST_DONE);
                state_d    = ST_IDLE;
                if (acc && eof_i) begin
                    err_d = 1'b1;
                    len_d = '0;
                end else if (acc && sof_i) begin
                    key_d[DATA_WIDTH-1:0] = dat_i;
                    cnt_d   = CNT_WIDTH'(1);
                    len_d   = '0;
                    state_d = ST_KEY;
                end
            end

            ST_KEY, ST_NON, ST_CNT: begin
                core_rst_d = 1'b1;
                if (acc) begin
                    if (eof_i) begin
                        err_d   = 1'b1;
                        len_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else if (sof_i) begin
                        key_d[DATA_WIDTH-1:0] = dat_i;
                        cnt_d   = CNT_WIDTH'(1);
                        state_d = ST_KEY;
                    end else if (state == ST_KEY) begin
                        key_d[{cnt, 3'b000} +: DATA_WIDTH] = dat_i;
                        if (cnt == CNT_WIDTH'(KEY_BYTES - 1)) begin
                            cnt_d   = '0;
                            state_d = ST_NON;
                        end else begin
                            cnt_d = cnt + CNT_WIDTH'(1);
                        end
                    end else if (state == ST_NON) begin
                        non_d[{cnt[3:0], 3'b000} +: DATA_WIDTH] = dat_i;
                        if (cnt == CNT_WIDTH'(NON_BYTES - 1)) begin
                            cnt_d   = '0;
                            state_d = ST_CNT;
                        end else begin
                            cnt_d = cnt + CNT_WIDTH'(1);
                        end
                    end else begin
                        ini_d[{cnt[1:0], 3'b000} +: DATA_WIDTH] = dat_i;
                        if (cnt == CNT_WIDTH'(INI_BYTES - 1)) begin
                            cnt_d      = '0;
                            first_d    = 1'b1;
                            core_rst_d = 1'b0;
                            state_d    = ST_PAY;
                        end else begin
                            cnt_d = cnt + CNT_WIDTH'(1);
                        end
                    end
                end
            end

            // acc implies cts_i here, so the output register is free to load.
            ST_PAY: begin
                core_rst_d = 1'b0;
                if (acc) begin
                    dat_o_d = dat_i;
                    val_o_d = 1'b1;
                    sof_o_d = first;
                    eof_o_d = eof_i;
                    first_d = 1'b0;
                    if (len != {LEN_WIDTH{1'b1}}) begin
                        len_d = len + LEN_WIDTH'(1);
                    end
                    if (eof_i) begin
                        state_d = ST_DONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef QNIGMA_CHACHA20_LOADER_STAT_EN
    // Free-running wrap-around counters of completed frames and header errors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frm_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (don_d) begin
                frm_cnt <= frm_cnt + FRM_CNT_WIDTH'(1);
            end
            if (err_d) begin
                err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_qnigma_chacha20_loader.sv
// Self-checking bench for qnigma_chacha20_loader: scoreboarded payload plus header/reset scenarios.
module tb_qnigma_chacha20_loader;
    import qnigma_chacha20_pkg::*;

    localparam int unsigned LEN_WIDTH = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [7:0]             dat_i;
    logic                   val_i;
    logic                   sof_i;
    logic                   eof_i;
    logic                   cts_o;
    logic [255:0]           key;
    logic [95:0]            non;
    logic [31:0]            ini;
    logic                   core_rst;
    logic [7:0]             dat_o;
    logic                   val_o;
    logic                   sof_o;
    logic                   eof_o;
    logic                   cts_i;
    logic [LEN_WIDTH-1:0]   len;
    logic                   err;
    logic                   don;
`ifdef QNIGMA_CHACHA20_LOADER_STAT_EN
    logic [31:0]            frm_cnt;
    logic [15:0]            err_cnt;
`endif

    qnigma_chacha20_loader #(.LEN_WIDTH(LEN_WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .dat_i    (dat_i),
        .val_i    (val_i),
        .sof_i    (sof_i),
        .eof_i    (eof_i),
        .cts_o    (cts_o),
        .key      (key),
        .non      (non),
        .ini      (ini),
        .core_rst (core_rst),
        .dat_o    (dat_o),
        .val_o    (val_o),
        .sof_o    (sof_o),
        .eof_o    (eof_o),
        .cts_i    (cts_i),
        .len      (len),
        .err      (err),
        .don      (don)
`ifdef QNIGMA_CHACHA20_LOADER_STAT_EN
        ,
        .frm_cnt  (frm_cnt),
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          checks;
    int          errors;
    logic [9:0]  exp_q[$];
    int          out_cnt;
    int          don_cnt;
    int          err_seen;
    bit          bp_en;
    bit          chk_cts;
    logic [7:0]  pay_buf[256];

    // Scoreboard: every beat the core takes must match the oldest expectation.
    task automatic monitor();
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (val_o && cts_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL out_unexpected got=%h sof=%b eof=%b want=none", dat_o, sof_o, eof_o);
                    end else begin
                        e = exp_q.pop_front();
                        if ({dat_o, sof_o, eof_o} !== e) begin
                            errors++;
                            $display("FAIL out_beat got=%h/%b/%b want=%h/%b/%b",
                                     dat_o, sof_o, eof_o, e[9:2], e[1], e[0]);
                        end
                    end
                    out_cnt++;
                end
                if (don) begin
                    don_cnt++;
                    checks++;
                    if (core_rst !== 1'b1) begin
                        errors++;
                        $display("FAIL don_core_rst got=%b want=1", core_rst);
                    end
                end
                if (err) err_seen++;
            end
        end
    endtask

    task automatic toggler();
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) cts_i = ~cts_i;
        end
    endtask

    task automatic drive_beat(input logic [7:0] d, input logic s, input logic e, output bit ok);
        int w;
        dat_i = d; sof_i = s; eof_i = e; val_i = 1'b1;
        w  = 0;
        ok = 1'b1;
        while (1) begin
            @(negedge clk);
            if (chk_cts) begin
                checks++;
                if (cts_o !== cts_i) begin
                    errors++;
                    $display("FAIL cts_track got=%b want=%b", cts_o, cts_i);
                end
            end
            if (cts_o) break;
            w++;
            if (w > 64) begin
                ok = 1'b0;
                checks++;
                errors++;
                $display("FAIL beat_timeout got=stalled want=accepted");
                break;
            end
        end
        @(posedge clk);
        #1;
        val_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
    endtask

    task automatic send_header(input logic [255:0] k, input logic [95:0] n, input logic [31:0] iv,
                               input int trunc_at);
        logic [7:0] b;
        bit ok;
        for (int idx = 0; idx < 48; idx++) begin
            if (idx < 32)      b = k[8*idx +: 8];
            else if (idx < 44) b = n[8*(idx-32) +: 8];
            else               b = iv[8*(idx-44) +: 8];
            if (idx == 47 && trunc_at < 0) begin
                checks++;
                if (core_rst !== 1'b1) begin
                    errors++;
                    $display("FAIL core_rst_before_ini got=%b want=1", core_rst);
                end
            end
            drive_beat(b, idx == 0, idx == trunc_at, ok);
            if (idx == trunc_at) return;
        end
    endtask

    task automatic send_payload(input int plen, input int sof_at, input bit last_eof);
        bit ok;
        chk_cts = 1'b1;
        for (int j = 0; j < plen; j++) begin
            drive_beat(pay_buf[j], j == sof_at, last_eof && (j == plen - 1), ok);
            if (ok) exp_q.push_back({pay_buf[j], j == 0, last_eof && (j == plen - 1)});
            if (last_eof && j == plen - 1) chk_cts = 1'b0;
        end
        chk_cts = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        for (int j = 0; j < n; j++) pay_buf[j] = 8'($urandom_range(0, 255));
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++;
        if ({val_o, sof_o, eof_o, err, don} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=00000", {val_o, sof_o, eof_o, err, don});
        end
        checks++;
        if (core_rst !== 1'b1 || cts_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_rst_cts got=%b%b want=11", core_rst, cts_o);
        end
        checks++;
        if (key !== 256'h0 || non !== 96'h0 || ini !== 32'h0 || len !== 16'h0 || dat_o !== 8'h0) begin
            errors++;
            $display("FAIL reset_regs got=%h/%h/%h/%h want=0", key, non, ini, len);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (core_rst !== 1'b1 || val_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got=%b%b want=10", core_rst, val_o);
        end
    endtask

    task automatic test_rfc_vector();
        logic [255:0] k;
        string        s;
        int           o0, d0;
        for (int i = 0; i < 32; i++) k[8*i +: 8] = 8'(i);
        s = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
        for (int j = 0; j < s.len(); j++) pay_buf[j] = s[j];
        o0 = out_cnt; d0 = don_cnt;
        send_header(k, 96'h00000000_4a000000_00000000, 32'h1, -1);
        checks++;
        if (key !== k) begin
            errors++;
            $display("FAIL rfc_key got=%h want=%h", key, k);
        end
        checks++;
        if (non !== 96'h00000000_4a000000_00000000 || ini !== 32'h1) begin
            errors++;
            $display("FAIL rfc_non_ini got=%h/%h want=00000000_4a000000_00000000/1", non, ini);
        end
        checks++;
        if (core_rst !== 1'b0) begin
            errors++;
            $display("FAIL rfc_core_rst_release got=%b want=0", core_rst);
        end
        send_payload(114, -1, 1'b1);
        wait_drain();
        checks++;
        if (len !== 16'd114 || out_cnt - o0 != 114) begin
            errors++;
            $display("FAIL rfc_len got=%0d/%0d want=114/114", len, out_cnt - o0);
        end
        checks++;
        if (don_cnt - d0 != 1) begin
            errors++;
            $display("FAIL rfc_don got=%0d want=1", don_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        int o0;
        o0 = out_cnt;
        fill_random(40);
        send_header(rand_key(), 96'h0123456789abcdef01234567, 32'h5, -1);
        bp_en = 1'b1;
        send_payload(40, 5, 1'b1);
        wait_drain();
        bp_en = 1'b0;
        @(posedge clk);
        #2;
        cts_i = 1'b1;
        checks++;
        if (len !== 16'd40 || out_cnt - o0 != 40) begin
            errors++;
            $display("FAIL bp_len got=%0d/%0d want=40/40", len, out_cnt - o0);
        end
    endtask

    task automatic test_truncated();
        int e0, o0;
        logic [255:0] k;
        e0 = err_seen; o0 = out_cnt;
        send_header(rand_key(), 96'hffeeddccbbaa998877665544, 32'h7, 37);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err_seen - e0 != 1) begin
            errors++;
            $display("FAIL trunc_err got=%0d want=1", err_seen - e0);
        end
        checks++;
        if (core_rst !== 1'b1 || len !== 16'd0 || out_cnt != o0) begin
            errors++;
            $display("FAIL trunc_state got=%b/%0d/%0d want=1/0/0", core_rst, len, out_cnt - o0);
        end
        k = rand_key();
        fill_random(16);
        send_header(k, 96'h1, 32'h2, -1);
        checks++;
        if (key !== k) begin
            errors++;
            $display("FAIL trunc_next_key got=%h want=%h", key, k);
        end
        send_payload(16, -1, 1'b1);
        wait_drain();
        checks++;
        if (len !== 16'd16) begin
            errors++;
            $display("FAIL trunc_next_len got=%0d want=16", len);
        end
    endtask

    task automatic test_zero_len();
        int e0, o0;
        bit ok;
        e0 = err_seen; o0 = out_cnt;
        send_header(rand_key(), 96'h2, 32'h3, 47);
        drive_beat(8'h55, 1'b0, 1'b0, ok);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err_seen - e0 != 1) begin
            errors++;
            $display("FAIL zero_err got=%0d want=1", err_seen - e0);
        end
        checks++;
        if (core_rst !== 1'b1 || len !== 16'd0 || out_cnt != o0 || val_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_state got=%b/%0d/%0d/%b want=1/0/0/0", core_rst, len, out_cnt - o0, val_o);
        end
    endtask

    task automatic test_reset_mid();
        fill_random(10);
        send_header(rand_key(), 96'h3, 32'h4, -1);
        send_payload(10, -1, 1'b0);
        checks++;
        if (len !== 16'd10) begin
            errors++;
            $display("FAIL mid_len_before got=%0d want=10", len);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({val_o, sof_o, eof_o, err, don} !== 5'b0 || dat_o !== 8'h0) begin
            errors++;
            $display("FAIL mid_ctrl got=%b/%h want=00000/00", {val_o, sof_o, eof_o, err, don}, dat_o);
        end
        checks++;
        if (core_rst !== 1'b1 || cts_o !== 1'b1 || len !== 16'd0) begin
            errors++;
            $display("FAIL mid_rst got=%b/%b/%0d want=1/1/0", core_rst, cts_o, len);
        end
        checks++;
        if (key !== 256'h0 || non !== 96'h0 || ini !== 32'h0) begin
            errors++;
            $display("FAIL mid_regs got=%h/%h/%h want=0", key, non, ini);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [255:0] ka, kb;
        int o0, d0;
        ka = rand_key();
        kb = ~ka;
        o0 = out_cnt; d0 = don_cnt;
        fill_random(20);
        send_header(ka, 96'hA, 32'h1, -1);
        send_payload(20, -1, 1'b1);
        fill_random(64);
        send_header(kb, 96'hB, 32'h9, -1);
        checks++;
        if (key !== kb || ini !== 32'h9) begin
            errors++;
            $display("FAIL b2b_key got=%h/%h want=%h/9", key, ini, kb);
        end
        checks++;
        if (don_cnt - d0 != 1 || core_rst !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_done got=%0d/%b want=1/0", don_cnt - d0, core_rst);
        end
        send_payload(64, -1, 1'b1);
        wait_drain();
        checks++;
        if (len !== 16'd64 || out_cnt - o0 != 84 || don_cnt - d0 != 2) begin
            errors++;
            $display("FAIL b2b_len got=%0d/%0d/%0d want=64/84/2", len, out_cnt - o0, don_cnt - d0);
        end
    endtask

    initial begin
        checks = 0; errors = 0; out_cnt = 0; don_cnt = 0; err_seen = 0;
        bp_en = 1'b0; chk_cts = 1'b0;
        rst = 1'b0; dat_i = '0; val_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0; cts_i = 1'b1;
        fork
            monitor();
            toggler();
        join_none
        test_reset();
        test_rfc_vector();
        test_backpressure();
        test_truncated();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
